// File: rtl/ram_port_sched_pkg.sv
// Shared definitions for the block-RAM port scheduler.
// Holds the default geometry (data/address width, requester count), the RAM
// read latency, the host starvation-guard limit and the FSM state encoding.
package ram_port_sched_pkg;

    localparam int SCHED_DW          = 16;  // RAM data width
    localparam int SCHED_AW          = 6;   // RAM address width (64 words)
    localparam int SCHED_NREQ        = 2;   // number of read requesters
    localparam int SCHED_RD_LAT      = 1;   // clocks from registered addr to valid dout
    localparam int SCHED_MAX_WSTREAK = 4;   // host grants allowed back-to-back while a reader waits

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ram_port_sched_rr_arbiter.sv
// Round-robin arbiter for the read requesters.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the most recently granted requester (owned by the parent)
//   grant - one-hot grant; the search starts at ptr+1 and wraps at NREQ
//   valid - at least one request present (grant is non-zero)
// Purely combinational.
module ram_port_sched_rr_arbiter
    import ram_port_sched_pkg::*;
#(
    parameter int NREQ = SCHED_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            valid
);

    localparam int W2 = 2 * NREQ;

    logic [PW:0]     shamt;
    logic [W2-1:0]   req_dbl;
    logic [W2-1:0]   rot_full;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] pick;
    logic [W2-1:0]   gnt_full;

    // Rotate the requests so that requester ptr+1 lands in bit 0, take the
    // lowest set bit, then rotate the one-hot result back. Duplicating the
    // vector turns the wrap-around into plain shifts.
    assign shamt    = {1'b0, ptr} + (PW+1)'(1);
    assign req_dbl  = {req, req};
    assign rot_full = req_dbl >> shamt;
    assign rot      = rot_full[NREQ-1:0];
    assign pick     = rot & (~rot + NREQ'(1));
    assign gnt_full = {{NREQ{1'b0}}, pick} << shamt;
    assign grant    = gnt_full[W2-1:NREQ] | gnt_full[NREQ-1:0];
    assign valid    = |req;

endmodule

// File: rtl/ram_port_sched.sv
// Scheduler for the single-port block RAM shared by the host loader (writes)
// and NREQ ALU-side readers.
// Ports:
//   c, rst                      - clock; asynchronous active-high reset
//   host_we/host_addr/host_din  - host write request (held until host_ack)
//   host_ack                    - one-cycle pulse, write issued to the RAM
//   rd_req/rd_addr              - per-requester read request, packed addresses
//   rd_ack                      - one-hot, one-cycle read grant
//   rd_valid/rd_data            - one-hot data-valid pulse; rd_data held until next read
//   busy                        - scheduler not idle
//   ram_we/ram_addr/ram_din     - RAM command (all registered)
//   ram_dout                    - RAM read data
// Host writes win arbitration unless readers have already been locked out for
// MAX_WSTREAK consecutive host grants. Every output is a register.
module ram_port_sched
    import ram_port_sched_pkg::*;
#(
    parameter int DW          = SCHED_DW,
    parameter int AW          = SCHED_AW,
    parameter int NREQ        = SCHED_NREQ,
    parameter int RD_LAT      = SCHED_RD_LAT,
    parameter int MAX_WSTREAK = SCHED_MAX_WSTREAK
) (
    input  logic               c,
    input  logic               rst,
    input  logic               host_we,
    input  logic [AW-1:0]      host_addr,
    input  logic [DW-1:0]      host_din,
    output logic               host_ack,
    input  logic [NREQ-1:0]    rd_req,
    input  logic [NREQ*AW-1:0] rd_addr,
    output logic [NREQ-1:0]    rd_ack,
    output logic [NREQ-1:0]    rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic               busy,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    input  logic [DW-1:0]      ram_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RD_LAT + 2);
    localparam int SW = $clog2(MAX_WSTREAK + 1);

    sched_state_t    state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [SW-1:0]   wstreak_reg, wstreak_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [NREQ-1:0] sel_reg, sel_next;       // requester whose read is in flight
    logic            host_ack_reg, host_ack_next;
    logic [NREQ-1:0] rd_ack_reg, rd_ack_next;
    logic [NREQ-1:0] rd_valid_reg, rd_valid_next;
    logic [DW-1:0]   rd_data_reg, rd_data_next;
    logic            busy_reg, busy_next;
    logic            ram_we_reg, ram_we_next;
    logic [AW-1:0]   ram_addr_reg, ram_addr_next;
    logic [DW-1:0]   ram_din_reg, ram_din_next;

    logic [NREQ-1:0] arb_grant;
    logic            arb_valid;
    logic [PW-1:0]   grant_idx;
    logic [AW-1:0]   grant_addr;
    logic [AW-1:0]   addr_slice [NREQ];
    logic            any_rd;
    logic            host_win;

    ram_port_sched_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (rd_req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_slice[gi] = rd_addr[gi*AW +: AW];
        end
    endgenerate

    always_comb begin
        grant_idx  = '0;
        grant_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                grant_idx  = PW'(i);
                grant_addr = addr_slice[i];
            end
        end
    end

    assign any_rd   = |rd_req;
    // Once the streak reaches the limit a waiting reader takes the next slot.
    assign host_win = host_we && (!any_rd || (wstreak_reg < SW'(MAX_WSTREAK)));

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        wstreak_next  = wstreak_reg;
        cnt_next      = cnt_reg;
        sel_next      = sel_reg;
        host_ack_next = 1'b0;
        rd_ack_next   = '0;
        rd_valid_next = '0;
        rd_data_next  = rd_data_reg;
        ram_we_next   = ram_we_reg;
        ram_addr_next = ram_addr_reg;
        ram_din_next  = ram_din_reg;

        case (state_reg)
            ST_IDLE: begin
                ram_we_next = 1'b0;
                if (host_win) begin
                    state_next    = ST_WRITE;
                    ram_we_next   = 1'b1;
                    ram_addr_next = host_addr;
                    ram_din_next  = host_din;
                    host_ack_next = 1'b1;
                    if (!any_rd) begin
                        wstreak_next = '0;
                    end else if (wstreak_reg != SW'(MAX_WSTREAK)) begin
                        wstreak_next = wstreak_reg + 1'b1;
                    end
                end else if (arb_valid) begin
                    state_next    = ST_READ;
                    ram_addr_next = grant_addr;
                    rd_ack_next   = arb_grant;
                    ptr_next      = grant_idx;
                    wstreak_next  = '0;
                    cnt_next      = '0;
                    sel_next      = arb_grant;
                end
            end
            ST_WRITE: begin
                ram_we_next = 1'b0;
                state_next  = ST_IDLE;
            end
            ST_READ: begin
                // First READ cycle sees cnt=0; dout is sampled RD_LAT+1
                // edges after the address was registered.
                if (cnt_reg == CW'(RD_LAT)) begin
                    rd_data_next  = ram_dout;
                    rd_valid_next = sel_reg;
                    state_next    = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= PW'(NREQ - 1);
            wstreak_reg  <= '0;
            cnt_reg      <= '0;
            sel_reg      <= '0;
            host_ack_reg <= 1'b0;
            rd_ack_reg   <= '0;
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
            busy_reg     <= 1'b0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            wstreak_reg  <= wstreak_next;
            cnt_reg      <= cnt_next;
            sel_reg      <= sel_next;
            host_ack_reg <= host_ack_next;
            rd_ack_reg   <= rd_ack_next;
            rd_valid_reg <= rd_valid_next;
            rd_data_reg  <= rd_data_next;
            busy_reg     <= busy_next;
            ram_we_reg   <= ram_we_next;
            ram_addr_reg <= ram_addr_next;
            ram_din_reg  <= ram_din_next;
        end
    end

    assign host_ack = host_ack_reg;
    assign rd_ack   = rd_ack_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign busy     = busy_reg;
    assign ram_we   = ram_we_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;

endmodule

// File: tb/tb_ram_port_sched.sv
// Bench for ram_port_sched: directed stimulus pushes expected events into an
// ordered queue; a monitor on the falling edge pops and compares each host_ack,
// rd_ack and rd_valid the DUT presents. A behavioural 64x16 RAM with one
// clock of read latency closes the loop.
module tb_ram_port_sched;
    import ram_port_sched_pkg::*;

    localparam int DW   = SCHED_DW;
    localparam int AW   = SCHED_AW;
    localparam int NREQ = SCHED_NREQ;

    localparam logic [1:0] K_HOST  = 2'd0;
    localparam logic [1:0] K_ACK   = 2'd1;
    localparam logic [1:0] K_VALID = 2'd2;

    typedef struct packed {
        logic [1:0]      kind;
        logic [NREQ-1:0] vec;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
    } exp_t;

    logic               c = 1'b0;
    logic               rst = 1'b1;
    logic               host_we = 1'b0;
    logic [AW-1:0]      host_addr = '0;
    logic [DW-1:0]      host_din = '0;
    logic               host_ack;
    logic [NREQ-1:0]    rd_req = '0;
    logic [NREQ*AW-1:0] rd_addr = '0;
    logic [NREQ-1:0]    rd_ack;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;
    logic               busy;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic [DW-1:0]      ram_dout = '0;

    ram_port_sched dut (
        .c         (c),
        .rst       (rst),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_ack  (host_ack),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 c = ~c;

    // Behavioural RAM: registered read, one clock of latency.
    logic [DW-1:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
    end
    always @(posedge c) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    exp_t exp_q[$];

    function automatic void exp_host(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({K_HOST, {NREQ{1'b0}}, a, d});
    endfunction
    function automatic void exp_ack(input logic [NREQ-1:0] v, input logic [AW-1:0] a);
        exp_q.push_back({K_ACK, v, a, {DW{1'b0}}});
    endfunction
    function automatic void exp_valid(input logic [NREQ-1:0] v, input logic [DW-1:0] d);
        exp_q.push_back({K_VALID, v, {AW{1'b0}}, d});
    endfunction

    // ---------------- monitor ----------------
    exp_t       mon_e;
    logic [1:0] obs_kind;
    logic       prev_we = 1'b0;
    int         last_ack_cyc = -100;
    int         last_host_cyc = -100;

    always @(negedge c) begin
        if (!rst) begin
            if (ram_we) chk("ram_we_single_cycle", 64'(prev_we), 64'd0);
            if (host_ack || (|rd_ack) || (|rd_valid)) begin
                obs_kind = host_ack ? K_HOST : ((|rd_ack) ? K_ACK : K_VALID);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: host_ack=%0b rd_ack=%b rd_valid=%b required none (cycle %0d)",
                             host_ack, rd_ack, rd_valid, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", 64'(obs_kind), 64'(mon_e.kind));
                    if (obs_kind == K_HOST) begin
                        $display("cycle %0d host write addr=%0d data=%h", cyc, ram_addr, ram_din);
                        chk("wr_we", 64'(ram_we), 64'd1);
                        chk("wr_addr", 64'(ram_addr), 64'(mon_e.addr));
                        chk("wr_data", 64'(ram_din), 64'(mon_e.data));
                        chk("busy_on_write", 64'(busy), 64'd1);
                        last_host_cyc = cyc;
                    end else if (obs_kind == K_ACK) begin
                        $display("cycle %0d read ack=%b addr=%0d", cyc, rd_ack, ram_addr);
                        chk("rd_ack_vec", 64'(rd_ack), 64'(mon_e.vec));
                        chk("rd_ram_addr", 64'(ram_addr), 64'(mon_e.addr));
                        chk("rd_ram_we", 64'(ram_we), 64'd0);
                        last_ack_cyc = cyc;
                    end else begin
                        $display("cycle %0d read valid=%b data=%h", cyc, rd_valid, rd_data);
                        chk("rd_valid_vec", 64'(rd_valid), 64'(mon_e.vec));
                        chk("rd_data", 64'(rd_data), 64'(mon_e.data));
                        chk("rd_valid_latency", 64'(cyc - last_ack_cyc), 64'd2);
                    end
                end
            end
        end
        prev_we <= ram_we;
    end

    // ---------------- driver ----------------
    logic [AW+DW-1:0] host_pend[$];
    int hold_acks = 0;   // 0: each requester drops its line on its own ack
    int ack_seen  = 0;

    task automatic add_host(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_pend.push_back({a, d});
        exp_host(a, d);
    endtask

    task automatic start_host();
        {host_addr, host_din} = host_pend[0];
        host_we = 1'b1;
    endtask

    task automatic drive_until_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge c);
            #1;
            n++;
            if (host_ack) begin
                void'(host_pend.pop_front());
                if (host_pend.size() != 0) {host_addr, host_din} = host_pend[0];
                else host_we = 1'b0;
            end
            if (|rd_ack) begin
                ack_seen++;
                if (hold_acks == 0) rd_req = rd_req & ~rd_ack;
                else if (ack_seen >= hold_acks) rd_req = '0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d expected events pending after %0d cycles, required 0", exp_q.size(), n);
            exp_q.delete();
            host_pend.delete();
            host_we = 1'b0;
            rd_req  = '0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_host_ack"}, 64'(host_ack), 64'd0);
        chk({tag, "_rd_ack"},   64'(rd_ack),   64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"},  64'(rd_data),  64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_ram_we"},   64'(ram_we),   64'd0);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_ram_din"},  64'(ram_din),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    int start_cyc;

    initial begin
        // Reset state
        repeat (2) @(negedge c);
        chk_all_zero("reset");
        @(posedge c); #1;
        rst = 1'b0;
        @(negedge c);
        chk_all_zero("after_release");

        // Single host write, no readers
        @(posedge c); #1;
        add_host(6'd5, 16'h1234);
        start_host();
        start_cyc = cyc;
        drive_until_done(20);
        chk("host_ack_latency", 64'(last_host_cyc - start_cyc), 64'd1);
        @(negedge c);
        chk("busy_after_write", 64'(busy), 64'd0);
        chk("ram_we_after_write", 64'(ram_we), 64'd0);
        chk("host_ack_pulse", 64'(host_ack), 64'd0);

        // Requester 1 reads back addr 5
        @(posedge c); #1;
        rd_addr[AW +: AW] = 6'd5;
        rd_req = 2'b10;
        exp_ack(2'b10, 6'd5);
        exp_valid(2'b10, 16'h1234);
        drive_until_done(20);
        repeat (3) @(negedge c);
        chk("rd_data_held", 64'(rd_data), 64'h1234);
        chk("rd_valid_idle", 64'(rd_valid), 64'd0);

        // Preload two more words
        @(posedge c); #1;
        add_host(6'd10, 16'hAAAA);
        add_host(6'd20, 16'h5555);
        start_host();
        drive_until_done(20);

        // Both requesters hold: grants alternate 0,1,0,1
        @(posedge c); #1;
        rd_addr[0 +: AW]  = 6'd10;
        rd_addr[AW +: AW] = 6'd20;
        hold_acks = 4;
        ack_seen  = 0;
        rd_req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            exp_ack(2'b01, 6'd10);
            exp_valid(2'b01, 16'hAAAA);
            exp_ack(2'b10, 6'd20);
            exp_valid(2'b10, 16'h5555);
        end
        drive_until_done(60);
        hold_acks = 0;

        // Host streams 10 writes while requester 0 waits: 4 writes, read, 6 writes
        @(posedge c); #1;
        for (int k = 0; k < 10; k++) begin
            host_pend.push_back({6'(30 + k), 16'(16'h1000 + k)});
        end
        for (int k = 0; k < 4; k++) exp_host(6'(30 + k), 16'(16'h1000 + k));
        exp_ack(2'b01, 6'd10);
        exp_valid(2'b01, 16'hAAAA);
        for (int k = 4; k < 10; k++) exp_host(6'(30 + k), 16'(16'h1000 + k));
        rd_req = 2'b01;
        start_host();
        drive_until_done(100);

        // Reset one cycle after a read grant: read is dropped
        @(posedge c); #1;
        rd_addr[AW +: AW] = 6'd20;
        rd_req = 2'b10;
        exp_ack(2'b10, 6'd20);
        drive_until_done(20);
        @(posedge c); #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(posedge c);
        #1;
        rst = 1'b0;
        @(negedge c);
        chk("no_valid_after_reset", 64'(rd_valid), 64'd0);

        // After reset requester 0 wins first, then requester 1
        @(posedge c); #1;
        rd_addr[0 +: AW]  = 6'd10;
        rd_addr[AW +: AW] = 6'd20;
        rd_req = 2'b11;
        exp_ack(2'b01, 6'd10);
        exp_valid(2'b01, 16'hAAAA);
        exp_ack(2'b10, 6'd20);
        exp_valid(2'b10, 16'h5555);
        drive_until_done(30);

        // Simultaneous host and reader with empty streak: host first
        @(posedge c); #1;
        add_host(6'd40, 16'hBEEF);
        exp_ack(2'b01, 6'd10);
        exp_valid(2'b01, 16'hAAAA);
        rd_addr[0 +: AW] = 6'd10;
        rd_req = 2'b01;
        start_host();
        drive_until_done(30);
        chk("read_after_write_gap", 64'(last_ack_cyc - last_host_cyc), 64'd2);

        // Read back data written earlier
        @(posedge c); #1;
        rd_addr[AW +: AW] = 6'd40;
        rd_req = 2'b10;
        exp_ack(2'b10, 6'd40);
        exp_valid(2'b10, 16'hBEEF);
        drive_until_done(20);
        @(posedge c); #1;
        rd_addr[0 +: AW] = 6'd33;
        rd_req = 2'b01;
        exp_ack(2'b01, 6'd33);
        exp_valid(2'b01, 16'h1003);
        drive_until_done(20);

        repeat (5) @(negedge c);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
